gpnae_batch_sched: RTL and testbench

GPNAE_BATCH_SCHED -- requirements
Module: gpnae_batch_sched

---
 rtl/gpnae_batch_sched.sv | 164 ++++++++++++++++
 tb/tb_gpnae_batch_sched.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/gpnae_batch_sched.sv
// ============================================================================
// gpnae_batch_sched : batch FIFO + scheduler feeding a single activation engine
// Rev 1.0
// ============================================================================
`default_nettype none

module gpnae_batch_sched #(
   parameter int DATA_WIDTH    = 32,
   parameter int ADDR_LINES    = 5,
   parameter int CONTROL_WIDTH = 2
) (
   input  logic                     clk_i,
   input  logic                     rstn_i,
   input  logic [DATA_WIDTH-1:0]    signal_i,
   input  logic                     wr_en_i,
   input  logic                     last_i,
   input  logic [CONTROL_WIDTH-1:0] control_word_i,
   input  logic [ADDR_LINES-1:0]    terms_i,
   output logic                     full_o,
   output logic                     empty_o,
   output logic                     idle_o,
   output logic [ADDR_LINES:0]      count_o,
   output logic [DATA_WIDTH-1:0]    eng_data_o,
   output logic [CONTROL_WIDTH-1:0] eng_mode_o,
   output logic [ADDR_LINES-1:0]    eng_terms_o,
   output logic                     eng_valid_o,
   input  logic                     eng_ready_i,
   input  logic [DATA_WIDTH-1:0]    eng_result_i,
   input  logic                     eng_done_i,
   output logic [DATA_WIDTH-1:0]    final_result_o,
   output logic                     done_o,
   output logic                     batch_done_o,
   output logic                     err_o
);

   localparam int DEPTH = 2**ADDR_LINES;
   localparam logic [ADDR_LINES-1:0]    PTR_ONE     = {{(ADDR_LINES-1){1'b0}}, 1'b1};
   localparam logic [ADDR_LINES:0]      CNT_ONE     = {{ADDR_LINES{1'b0}}, 1'b1};
   localparam logic [CONTROL_WIDTH-1:0] MODE_BYPASS = '0;

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_FILL  = 2'd1,
      S_ISSUE = 2'd2,
      S_WAIT  = 2'd3
   } state_t;

   state_t                     state, state_nx;
   logic [DATA_WIDTH-1:0]      mem [0:DEPTH-1];
   logic [ADDR_LINES-1:0]      wr_ptr, rd_ptr;
   logic [ADDR_LINES:0]        count;
   logic [CONTROL_WIDTH-1:0]   mode_q;
   logic [ADDR_LINES-1:0]      terms_q;
   logic                       full, empty;
   logic                       push, pop, latch, err_set, done_set, bd_set, res_from_eng;

   // Occupancy never exceeds DEPTH, so the MSB alone flags full.
   assign full  = count[ADDR_LINES];
   assign empty = (count == '0);

   always_ff @(posedge clk_i or negedge rstn_i) begin
      if (!rstn_i) state <= S_IDLE;
      else         state <= state_nx;
   end

   always_comb begin
      state_nx     = state;
      push         = 1'b0;
      pop          = 1'b0;
      latch        = 1'b0;
      err_set      = 1'b0;
      done_set     = 1'b0;
      bd_set       = 1'b0;
      res_from_eng = 1'b0;
      if (eng_done_i && state != S_WAIT) err_set = 1'b1;
      case (state)
         S_IDLE: begin
            if (wr_en_i) begin
               latch    = 1'b1;
               push     = !full;
               err_set  = err_set | full;
               state_nx = last_i ? S_ISSUE : S_FILL;
            end
         end
         S_FILL: begin
            if (wr_en_i) begin
               push    = !full;
               err_set = err_set | full;
               if (last_i) state_nx = S_ISSUE;
            end
         end
         S_ISSUE: begin
            if (wr_en_i) err_set = 1'b1;
            if (empty) begin
               bd_set   = 1'b1;
               state_nx = S_IDLE;
            end else if (mode_q == MODE_BYPASS) begin
               pop      = 1'b1;
               done_set = 1'b1;
               if (count == CNT_ONE) begin
                  bd_set   = 1'b1;
                  state_nx = S_IDLE;
               end
            end else if (eng_ready_i) begin
               pop      = 1'b1;
               state_nx = S_WAIT;
            end
         end
         S_WAIT: begin
            if (wr_en_i) err_set = 1'b1;
            if (eng_done_i) begin
               done_set     = 1'b1;
               res_from_eng = 1'b1;
               bd_set       = empty;
               state_nx     = empty ? S_IDLE : S_ISSUE;
            end
         end
         default: state_nx = S_IDLE;
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (push) mem[wr_ptr] <= signal_i;
   end

   always_ff @(posedge clk_i or negedge rstn_i) begin
      if (!rstn_i) begin
         wr_ptr         <= '0;
         rd_ptr         <= '0;
         count          <= '0;
         mode_q         <= '0;
         terms_q        <= '0;
         final_result_o <= '0;
         done_o         <= 1'b0;
         batch_done_o   <= 1'b0;
         err_o          <= 1'b0;
      end else begin
         if (push) wr_ptr <= wr_ptr + PTR_ONE;
         if (pop)  rd_ptr <= rd_ptr + PTR_ONE;
         if (push && !pop)      count <= count + CNT_ONE;
         else if (pop && !push) count <= count - CNT_ONE;
         if (latch) begin
            mode_q  <= control_word_i;
            terms_q <= terms_i;
         end
         if (done_set) final_result_o <= res_from_eng ? eng_result_i : mem[rd_ptr];
         done_o       <= done_set;
         batch_done_o <= bd_set;
         if (err_set) err_o <= 1'b1;
      end
   end

   assign full_o      = full;
   assign empty_o     = empty;
   assign idle_o      = (state == S_IDLE);
   assign count_o     = count;
   assign eng_data_o  = mem[rd_ptr];
   assign eng_mode_o  = mode_q;
   assign eng_terms_o = terms_q;
   assign eng_valid_o = (state == S_ISSUE) && (mode_q != MODE_BYPASS) && !empty;

endmodule

`default_nettype wire

// File: tb/tb_gpnae_batch_sched.sv
// ============================================================================
// tb_gpnae_batch_sched : vector table plus directed multi-cycle sequences
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_gpnae_batch_sched;

   logic        clk = 1'b0;
   logic        rstn;
   logic [31:0] signal;
   logic        wr_en, last;
   logic [1:0]  control_word;
   logic [4:0]  terms;
   logic        full, empty, idle;
   logic [5:0]  count;
   logic [31:0] eng_data;
   logic [1:0]  eng_mode;
   logic [4:0]  eng_terms;
   logic        eng_valid, eng_ready, eng_done;
   logic [31:0] eng_result, final_result;
   logic        done, batch_done, err;

   int n_vec = 0;
   int n_bad = 0;

   always #5 clk = ~clk;

   gpnae_batch_sched #(.DATA_WIDTH(32), .ADDR_LINES(5), .CONTROL_WIDTH(2)) dut (
      .clk_i(clk), .rstn_i(rstn), .signal_i(signal), .wr_en_i(wr_en), .last_i(last),
      .control_word_i(control_word), .terms_i(terms), .full_o(full), .empty_o(empty),
      .idle_o(idle), .count_o(count), .eng_data_o(eng_data), .eng_mode_o(eng_mode),
      .eng_terms_o(eng_terms), .eng_valid_o(eng_valid), .eng_ready_i(eng_ready),
      .eng_result_i(eng_result), .eng_done_i(eng_done), .final_result_o(final_result),
      .done_o(done), .batch_done_o(batch_done), .err_o(err)
   );

   typedef struct {
      logic wr; logic lst; logic [1:0] mode; logic [4:0] trm; logic [31:0] data;
      logic rdy; logic edone; logic [31:0] eres;
      logic x_idle; logic [5:0] x_cnt; logic x_valid; logic [31:0] x_edata;
      logic x_done; logic x_bd; logic [31:0] x_fres; logic x_err; logic [1:0] x_mode;
   } vec_t;

   vec_t vq[$];

   task automatic add(input logic wr, input logic lst, input logic [1:0] mode, input logic [4:0] trm,
                      input logic [31:0] data, input logic rdy, input logic edone, input logic [31:0] eres,
                      input logic x_idle, input logic [5:0] x_cnt, input logic x_valid,
                      input logic [31:0] x_edata, input logic x_done, input logic x_bd,
                      input logic [31:0] x_fres, input logic x_err, input logic [1:0] x_mode);
      vec_t v;
      v.wr = wr; v.lst = lst; v.mode = mode; v.trm = trm; v.data = data;
      v.rdy = rdy; v.edone = edone; v.eres = eres;
      v.x_idle = x_idle; v.x_cnt = x_cnt; v.x_valid = x_valid; v.x_edata = x_edata;
      v.x_done = x_done; v.x_bd = x_bd; v.x_fres = x_fres; v.x_err = x_err; v.x_mode = x_mode;
      vq.push_back(v);
   endtask

   task automatic chk(input string nm, input logic [95:0] act, input logic [95:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic clr();
      wr_en = 1'b0; last = 1'b0; eng_ready = 1'b0; eng_done = 1'b0;
   endtask

   task automatic do_reset();
      clr();
      rstn = 1'b0;
      repeat (2) tick();
      rstn = 1'b1;
      tick();
   endtask

   task automatic wr(input logic [31:0] d, input logic l, input logic [1:0] m, input logic [4:0] t);
      signal = d; wr_en = 1'b1; last = l; control_word = m; terms = t;
      tick();
      wr_en = 1'b0; last = 1'b0;
   endtask

   // Engine model: accepts each request, answers the bitwise inverse one cycle later.
   task automatic serve(input int first, input int n, input int total, input logic [31:0] base);
      int k;
      for (int i = first; i < first + n; i++) begin
         k = 0;
         while (!eng_valid && k < 20) begin
            tick();
            k++;
         end
         chk("eng_valid", 96'(eng_valid), 96'(1'b1));
         chk("eng_data", 96'(eng_data), 96'(base + i));
         eng_ready = 1'b1;
         tick();
         eng_ready = 1'b0;
         chk("one_outstanding", 96'({eng_valid, done}), 96'(2'b00));
         eng_result = ~(base + i);
         eng_done = 1'b1;
         tick();
         eng_done = 1'b0;
         chk("result", 96'({done, batch_done, final_result}),
             96'({1'b1, (i == total - 1), ~(base + i)}));
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, time %0t", $time);
      $fatal(1, "watchdog");
   end

   initial begin
      vec_t v;
      logic [31:0] bv [4];
      bv[0] = 32'h3F800000; bv[1] = 32'h40000000; bv[2] = 32'h40400000; bv[3] = 32'h40800000;

      //  wr l md tm data         r  d eres      idle cnt val edata  dn bd fres          er md
      add(1, 0, 1, 14, 'h11,       0, 0, 0,       0,   1,  0,  0,     0, 0, 0,            0, 1);
      add(1, 1, 2, 3,  'h22,       0, 0, 0,       0,   2,  1,  'h11,  0, 0, 0,            0, 1);
      add(0, 0, 0, 0,  0,          0, 0, 0,       0,   2,  1,  'h11,  0, 0, 0,            0, 1);
      add(0, 0, 0, 0,  0,          1, 0, 0,       0,   1,  0,  0,     0, 0, 0,            0, 1);
      add(0, 0, 0, 0,  0,          0, 1, 'hAAAA,  0,   1,  1,  'h22,  1, 0, 'hAAAA,       0, 1);
      add(0, 0, 0, 0,  0,          1, 0, 0,       0,   0,  0,  0,     0, 0, 'hAAAA,       0, 1);
      add(0, 0, 0, 0,  0,          0, 1, 'hBBBB,  1,   0,  0,  0,     1, 1, 'hBBBB,       0, 1);
      add(0, 0, 0, 0,  0,          0, 0, 0,       1,   0,  0,  0,     0, 0, 'hBBBB,       0, 1);
      add(0, 0, 0, 0,  0,          0, 1, 'hCCCC,  1,   0,  0,  0,     0, 0, 'hBBBB,       1, 1);
      add(1, 0, 0, 3,  'h3F800000, 0, 0, 0,       0,   1,  0,  0,     0, 0, 'hBBBB,       1, 0);
      add(1, 1, 1, 5,  'h40000000, 0, 0, 0,       0,   2,  0,  0,     0, 0, 'hBBBB,       1, 0);
      add(0, 0, 0, 0,  0,          0, 0, 0,       0,   1,  0,  0,     1, 0, 'h3F800000,   1, 0);
      add(0, 0, 0, 0,  0,          0, 0, 0,       1,   0,  0,  0,     1, 1, 'h40000000,   1, 0);
      add(0, 0, 0, 0,  0,          0, 0, 0,       1,   0,  0,  0,     0, 0, 'h40000000,   1, 0);

      signal = '0; control_word = '0; terms = '0; eng_result = '0;
      do_reset();
      chk("reset", 96'({idle, empty, full, count, eng_valid, done, batch_done, err, final_result, eng_mode, eng_terms}),
          96'({1'b1, 1'b1, 1'b0, 6'd0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 2'b00, 5'd0}));

      foreach (vq[i]) begin
         v = vq[i];
         wr_en = v.wr; last = v.lst; control_word = v.mode; terms = v.trm; signal = v.data;
         eng_ready = v.rdy; eng_done = v.edone; eng_result = v.eres;
         tick();
         chk($sformatf("vec%0d", i),
             96'({idle, count, eng_valid, (v.x_valid ? eng_data : 32'h0), done, batch_done, final_result, err, eng_mode}),
             96'({v.x_idle, v.x_cnt, v.x_valid, v.x_edata, v.x_done, v.x_bd, v.x_fres, v.x_err, v.x_mode}));
      end
      clr();

      // 30-sample SELU batch with a 10-cycle engine stall
      do_reset();
      for (int i = 0; i < 30; i++) wr(32'h10000000 + i, (i == 29), 2'b01, 5'd14);
      chk("selu_loaded", 96'({count, eng_valid, eng_mode, eng_terms, eng_data}),
          96'({6'd30, 1'b1, 2'b01, 5'd14, 32'h10000000}));
      repeat (10) begin
         tick();
         chk("stall", 96'({count, eng_valid, eng_data}), 96'({6'd30, 1'b1, 32'h10000000}));
      end
      serve(0, 30, 30, 32'h10000000);
      chk("selu_end", 96'({idle, empty, err, eng_mode, eng_terms}), 96'({1'b1, 1'b1, 1'b0, 2'b01, 5'd14}));

      // overflow: 33 writes into 32 entries
      do_reset();
      for (int i = 0; i < 32; i++) wr(32'h20000000 + i, 1'b0, 2'b10, 5'd7);
      chk("full", 96'({full, count, err}), 96'({1'b1, 6'd32, 1'b0}));
      wr(32'hDEADBEEF, 1'b1, 2'b10, 5'd7);
      chk("overflow", 96'({full, count, err, eng_valid}), 96'({1'b1, 6'd32, 1'b1, 1'b1}));
      serve(0, 32, 32, 32'h20000000);
      chk("overflow_end", 96'({idle, empty, err}), 96'({1'b1, 1'b1, 1'b1}));

      // bypass batch streams out one result per cycle
      do_reset();
      for (int i = 0; i < 4; i++) wr(bv[i], (i == 3), 2'b00, 5'd0);
      chk("byp_loaded", 96'({count, eng_valid, done}), 96'({6'd4, 1'b0, 1'b0}));
      for (int i = 0; i < 4; i++) begin
         tick();
         chk("bypass", 96'({done, batch_done, eng_valid, final_result}),
             96'({1'b1, (i == 3), 1'b0, bv[i]}));
      end
      tick();
      chk("byp_hold", 96'({done, idle, eng_valid, final_result}), 96'({1'b0, 1'b1, 1'b0, bv[3]}));

      // reset while waiting on sample 5 of 30
      do_reset();
      for (int i = 0; i < 30; i++) wr(32'h30000000 + i, (i == 29), 2'b11, 5'd9);
      serve(0, 4, 30, 32'h30000000);
      chk("pre_wait", 96'({eng_valid, eng_data}), 96'({1'b1, 32'h30000004}));
      eng_ready = 1'b1;
      tick();
      eng_ready = 1'b0;
      rstn = 1'b0;
      #1;
      chk("mid_reset", 96'({idle, empty, full, count, eng_valid, done, batch_done, err, final_result, eng_mode, eng_terms}),
          96'({1'b1, 1'b1, 1'b0, 6'd0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 2'b00, 5'd0}));
      @(negedge clk);
      rstn = 1'b1;
      tick();
      eng_result = 32'h12345678;
      eng_done = 1'b1;
      tick();
      eng_done = 1'b0;
      chk("late_done", 96'({done, err, idle, final_result}), 96'({1'b0, 1'b1, 1'b1, 32'h0}));

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule

`default_nettype wire
